// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI flash arbiter.
//   - FSM state encoding (IDLE, GRANT0, GRANT1, GAP)
//   - requester index constants (JTAG bridge, fabric SPI master)
//   - flash drive bundle and its parked value (csn high, sclk/mosi low)
package spi_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_GRANT0 = 2'd1;
    localparam state_t ST_GRANT1 = 2'd2;
    localparam state_t ST_GAP    = 2'd3;

    localparam logic REQ_JTAG   = 1'b0;
    localparam logic REQ_FABRIC = 1'b1;

    typedef struct packed {
        logic csn;
        logic sclk;
        logic mosi;
    } flash_drv_t;

    localparam flash_drv_t FLASH_PARK = '{csn: 1'b1, sclk: 1'b0, mosi: 1'b0};

endpackage

// File: rtl/spi_flash_arbiter_if.sv
// Bus bundle between the two SPI requesters, the arbiter and the shared flash.
//   req[1:0]        request per requester (bit 0 JTAG bridge, bit 1 fabric master)
//   gnt[1:0]        one-hot-or-zero grant
//   m_csn/m_sclk/m_mosi[1:0]  per-requester SPI drive
//   m_miso[1:0]     per-requester returned flash data
//   flash_csn/flash_sclk/flash_mosi  registered drive to the flash
//   flash_miso      data from the flash
//   timeout_evt     one-cycle pulse on forced release
// slave = arbiter side, master = requesters/flash side.
interface spi_flash_arbiter_if;

    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] m_csn;
    logic [1:0] m_sclk;
    logic [1:0] m_mosi;
    logic [1:0] m_miso;
    logic       flash_csn;
    logic       flash_sclk;
    logic       flash_mosi;
    logic       flash_miso;
    logic       timeout_evt;

    modport slave (
        input  req, m_csn, m_sclk, m_mosi, flash_miso,
        output gnt, m_miso, flash_csn, flash_sclk, flash_mosi, timeout_evt
    );

    modport master (
        output req, m_csn, m_sclk, m_mosi, flash_miso,
        input  gnt, m_miso, flash_csn, flash_sclk, flash_mosi, timeout_evt
    );

endinterface

// File: rtl/spi_arb_timer.sv
// Loadable saturating down-counter with a done flag.
//   clk, rst_n   clock and asynchronous active-low reset (count resets to 0)
//   load_i       load load_val_i (has priority over dec_i)
//   load_val_i   value to load
//   dec_i        decrement by one; holds at zero, never wraps
//   done_o       count is zero
module spi_arb_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/spi_flash_arbiter.sv
// Two-requester arbiter for a shared SPI flash.
//   clk     single clock, posedge
//   rst_n   asynchronous active-low reset; release is synchronised internally
//   bus     spi_flash_arbiter_if.slave (requests, grants, SPI muxing, timeout pulse)
// A grant is held until the owner drops req with csn high, or until the owner
// sits idle (csn high, req high) for IDLE_TIMEOUT cycles. Every release is
// followed by GAP_CYCLES cycles with the flash parked before re-arbitration.
// Ties go to the requester not served last.
module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input logic                clk,
    input logic                rst_n,
    spi_flash_arbiter_if.slave bus
);

    // Timers count down from N-1 so that done marks the Nth cycle.
    localparam logic [7:0]  GapLoad  = 8'(GAP_CYCLES - 1);
    localparam logic [15:0] IdleLoad = 16'(IDLE_TIMEOUT - 1);

    logic [1:0] rst_sync_q;
    logic       run;
    state_t     state_d, state_q;
    logic       last_d, last_q;
    logic       timeout_d, timeout_q;
    flash_drv_t flash_d, flash_q;
    logic       gap_load, gap_dec, gap_done;
    logic       idle_load, idle_dec, idle_done;
    logic       in_grant, sel, cur_csn, cur_req, pick_fabric;

    // Reset assertion is asynchronous everywhere; this only delays the FSM
    // from leaving IDLE until release has been seen on two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run = rst_sync_q[1];

    assign in_grant = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
    assign sel      = (state_q == ST_GRANT1) ? REQ_FABRIC : REQ_JTAG;
    assign cur_csn  = bus.m_csn[sel];
    assign cur_req  = bus.req[sel];

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        timeout_d   = 1'b0;
        gap_load    = 1'b0;
        gap_dec     = 1'b0;
        idle_load   = 1'b0;
        idle_dec    = 1'b0;
        pick_fabric = (bus.req == 2'b11) ? ~last_q : bus.req[REQ_FABRIC];

        case (state_q)
            ST_IDLE: begin
                if (run && (bus.req != 2'b00)) begin
                    state_d   = pick_fabric ? ST_GRANT1 : ST_GRANT0;
                    last_d    = pick_fabric;
                    idle_load = 1'b1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (!cur_csn) begin
                    // Mid-transaction: never release, restart the idle timer.
                    idle_load = 1'b1;
                end else if (!cur_req) begin
                    state_d  = ST_GAP;
                    gap_load = 1'b1;
                end else if (idle_done) begin
                    state_d   = ST_GAP;
                    gap_load  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    idle_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Flash follows the owner only while the grant continues across the edge,
    // so the first grant cycle and every GAP cycle see the parked value.
    always_comb begin
        flash_d = FLASH_PARK;
        if (in_grant && (state_d == state_q)) begin
            flash_d = '{csn: bus.m_csn[sel], sclk: bus.m_sclk[sel], mosi: bus.m_mosi[sel]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= REQ_FABRIC;
            timeout_q <= 1'b0;
            flash_q   <= FLASH_PARK;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
            flash_q   <= flash_d;
        end
    end

    spi_arb_timer #(
        .Width (8)
    ) u_gap_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (gap_load),
        .load_val_i (GapLoad),
        .dec_i      (gap_dec),
        .done_o     (gap_done)
    );

    spi_arb_timer #(
        .Width (16)
    ) u_idle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (idle_load),
        .load_val_i (IdleLoad),
        .dec_i      (idle_dec),
        .done_o     (idle_done)
    );

    assign bus.gnt         = {state_q == ST_GRANT1, state_q == ST_GRANT0};
    assign bus.m_miso      = {bus.flash_miso & (state_q == ST_GRANT1),
                              bus.flash_miso & (state_q == ST_GRANT0)};
    assign bus.flash_csn   = flash_q.csn;
    assign bus.flash_sclk  = flash_q.sclk;
    assign bus.flash_mosi  = flash_q.mosi;
    assign bus.timeout_evt = timeout_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_spi_flash_arbiter;

    localparam int GapCycles   = 4;
    localparam int IdleTimeout = 16;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    spi_flash_arbiter_if bus ();

    spi_flash_arbiter #(
        .GAP_CYCLES   (GapCycles),
        .IDLE_TIMEOUT (IdleTimeout)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_phase: 0 free, 1 owned by m_owner, 2 cooling down after a release
    int         m_phase;
    logic       m_owner;
    logic       m_last;
    int         m_idle;     // consecutive idle-held cycles of the owner
    int         m_gap;      // cooldown cycles already spent
    int         m_edges;    // edges seen since reset release
    logic [2:0] m_flash;    // {csn, sclk, mosi}
    logic       m_evt;

    task automatic model_reset();
        m_phase = 0;
        m_owner = 1'b0;
        m_last  = 1'b1;
        m_idle  = 0;
        m_gap   = 0;
        m_edges = 0;
        m_flash = 3'b100;
        m_evt   = 1'b0;
    endtask

    task automatic model_step();
        int   nxt;
        logic nown;
        logic evt;
        logic c;
        logic r;
        nxt  = m_phase;
        nown = m_owner;
        evt  = 1'b0;
        if (m_phase == 0) begin
            if (m_edges >= 2 && bus.req != 2'b00) begin
                nown   = (bus.req == 2'b11) ? ~m_last : bus.req[1];
                m_last = nown;
                m_idle = 0;
                nxt    = 1;
            end
        end else if (m_phase == 1) begin
            c = bus.m_csn[m_owner];
            r = bus.req[m_owner];
            if (!c) begin
                m_idle = 0;
            end else if (!r) begin
                nxt   = 2;
                m_gap = 1;
            end else if (m_idle == IdleTimeout - 1) begin
                nxt   = 2;
                m_gap = 1;
                evt   = 1'b1;
            end else begin
                m_idle++;
            end
        end else begin
            if (m_gap == GapCycles) nxt = 0;
            else m_gap++;
        end
        if (m_phase == 1 && nxt == 1) begin
            m_flash = {bus.m_csn[m_owner], bus.m_sclk[m_owner], bus.m_mosi[m_owner]};
        end else begin
            m_flash = 3'b100;
        end
        m_evt   = evt;
        m_phase = nxt;
        m_owner = nown;
        if (m_edges < 2) m_edges++;
    endtask

    initial begin : compare
        logic [1:0] eg;
        logic [1:0] em;
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            @(negedge clk);
            if (!rst_n) model_reset();
            eg = (m_phase == 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            em = bus.flash_miso ? eg : 2'b00;
            chk("model", {24'b0, bus.gnt, bus.m_miso, bus.flash_csn, bus.flash_sclk,
                          bus.flash_mosi, bus.timeout_evt},
                {24'b0, eg, em, m_flash, m_evt});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req        = 2'b00;
        bus.m_csn      = 2'b11;
        bus.m_sclk     = 2'b00;
        bus.m_mosi     = 2'b00;
        bus.flash_miso = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic rand_flip(input int div);
        if ($urandom_range(9) == 0) bus.req[0] = ~bus.req[0];
        if ($urandom_range(9) == 0) bus.req[1] = ~bus.req[1];
        if ($urandom_range(div - 1) == 0) bus.m_csn[0] = ~bus.m_csn[0];
        if ($urandom_range(div - 1) == 0) bus.m_csn[1] = ~bus.m_csn[1];
    endtask

    initial begin : stim
        logic [7:0] tx;
        logic [7:0] rx;
        int         div;
        rst_n = 1'b0;
        idle_inputs();
        do_reset();

        // Reset state
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_csn", 32'(bus.flash_csn), 1);
        chk("rst_evt", 32'(bus.timeout_evt), 0);

        // Single request, sclk delay, byte pass-through
        bus.req = 2'b01;
        step();
        chk("single_gnt", 32'(bus.gnt), 1);
        bus.m_csn[0] = 1'b0;
        step();
        chk("single_csn", 32'(bus.flash_csn), 0);
        bus.m_sclk[0] = 1'b1;
        #1;
        chk("sclk_before", 32'(bus.flash_sclk), 0);
        step();
        chk("sclk_after", 32'(bus.flash_sclk), 1);
        bus.flash_miso = 1'b1;
        #1;
        chk("miso_route", 32'(bus.m_miso), 1);
        tx = 8'h9F;
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bus.m_sclk[0] = 1'b0;
            bus.m_mosi[0] = tx[i];
            step();
            rx = {rx[6:0], bus.flash_mosi};
            bus.m_sclk[0] = 1'b1;
            step();
        end
        chk("byte_9f", 32'(rx), 'h9F);
        bus.m_csn[0]  = 1'b1;
        bus.m_sclk[0] = 1'b0;
        bus.req       = 2'b00;
        step();
        chk("release_gnt", 32'(bus.gnt), 0);
        for (int i = 0; i < 5; i++) step();

        // Tie after reset, then gap, then the other requester
        idle_inputs();
        do_reset();
        bus.req = 2'b11;
        step();
        chk("tie_first", 32'(bus.gnt), 1);
        bus.req = 2'b10;
        step();
        for (int i = 0; i < GapCycles; i++) begin
            chk("gap_gnt", 32'(bus.gnt), 0);
            chk("gap_csn", 32'(bus.flash_csn), 1);
            step();
        end
        chk("gap_exit_idle", 32'(bus.gnt), 0);
        step();
        chk("tie_second", 32'(bus.gnt), 2);

        // Isolation of the non-granted requester
        bus.m_csn[0]   = 1'b0;
        bus.flash_miso = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.m_sclk[0] = ~bus.m_sclk[0];
            step();
            chk("iso_sclk", 32'(bus.flash_sclk), 0);
            chk("iso_miso", 32'(bus.m_miso), 2);
        end
        idle_inputs();
        for (int i = 0; i < 7; i++) step();

        // Request dropped mid-byte
        do_reset();
        bus.req = 2'b01;
        step();
        bus.m_csn[0] = 1'b0;
        step();
        bus.req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drop_hold_gnt", 32'(bus.gnt), 1);
            chk("drop_hold_csn", 32'(bus.flash_csn), 0);
        end
        bus.m_csn[0] = 1'b1;
        step();
        for (int i = 0; i < GapCycles; i++) begin
            chk("drop_gap_gnt", 32'(bus.gnt), 0);
            chk("drop_gap_csn", 32'(bus.flash_csn), 1);
            step();
        end

        // Idle timeout with the other requester pending
        idle_inputs();
        do_reset();
        bus.req = 2'b01;
        step();
        bus.req = 2'b11;
        for (int i = 1; i < IdleTimeout; i++) begin
            chk("to_hold_gnt", 32'(bus.gnt), 1);
            chk("to_hold_evt", 32'(bus.timeout_evt), 0);
            step();
        end
        chk("to_last_gnt", 32'(bus.gnt), 1);
        step();
        chk("to_evt", 32'(bus.timeout_evt), 1);
        chk("to_gnt", 32'(bus.gnt), 0);
        step();
        chk("to_evt_clear", 32'(bus.timeout_evt), 0);
        step();
        step();
        step();
        chk("to_idle", 32'(bus.gnt), 0);
        step();
        chk("to_next_gnt", 32'(bus.gnt), 2);

        // Asynchronous reset mid-transfer
        bus.m_csn[1]   = 1'b0;
        bus.flash_miso = 1'b1;
        step();
        chk("mid_csn", 32'(bus.flash_csn), 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_csn", 32'(bus.flash_csn), 1);
        chk("async_gnt", 32'(bus.gnt), 0);
        chk("async_miso", 32'(bus.m_miso), 0);
        idle_inputs();
        do_reset();

        // Randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            div = (((cyc / 256) % 2) == 0) ? 4 : 40;
            rand_flip(div);
            bus.m_sclk     = 2'($urandom);
            bus.m_mosi     = 2'($urandom);
            bus.flash_miso = 1'($urandom);
            if ((cyc % 1500) == 1499) do_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
